// File: rtl/uc_multiciclo.sv
// Multicycle control unit: FETCH/DECODE/EXEC/[MEM]/PCUPD, 4 cycles per ALU/branch/jump op, 4+MEM_LATENCY for LD/SD.
// Outputs are registered; define UC_SINGLE_STEP_EN to add a step input that gates each instruction.
module uc_multiciclo #(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
`ifdef UC_SINGLE_STEP_EN
  input  logic             step,
`endif
  input  logic [31:0]      ir,
  input  logic             beq,
  input  logic             bne,
  input  logic             blt,
  input  logic             bge,
  input  logic             bltu,
  input  logic             bgeu,
  output logic             load_pc,
  output logic             load_ir,
  output logic             we_rf,
  output logic             we_ram,
  output logic             alu_b_imm,
  output logic             alu_sub,
  output logic             wb_mem,
  output logic             wb_pc,
  output logic             pc_imm,
  output logic             pc_rs1,
  output logic             busy,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_SD    = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [3:0] LAT_M1   = 4'(MEM_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_PCUPD, S_TRAP
  } state_t;

  state_t           state_q;
  logic [6:0]       op_q;
  logic [3:0]       mem_cnt_q;
  logic [CNT_W-1:0] instret_q;
  logic load_pc_q, load_ir_q, we_rf_q, we_ram_q, alu_b_imm_q, alu_sub_q;
  logic wb_mem_q, wb_pc_q, pc_imm_q, pc_rs1_q, busy_q, illegal_q;

  logic legal_d, take_d, start_d, is_ld_d, is_sd_d;

`ifdef UC_SINGLE_STEP_EN
  logic unused_ir;
  assign unused_ir = ^{ir[31], ir[29:15], ir[11:7], run};
`else
  logic unused_ir;
  assign unused_ir = ^{ir[31], ir[29:15], ir[11:7]};
`endif

  always_comb begin
    legal_d = 1'b0;
    take_d  = 1'b0;
`ifdef UC_SINGLE_STEP_EN
    start_d = step;
`else
    start_d = run;
`endif
    is_ld_d = (op_q == OP_LD);
    is_sd_d = (op_q == OP_SD);
    case (ir[6:0])
      OP_LD, OP_SD, OP_AUIPC, OP_JAL, OP_JALR: legal_d = 1'b1;
      OP_IMM, OP_ALU: legal_d = (ir[14:12] == 3'b000);
      OP_BR:          legal_d = (ir[14:13] != 2'b01);
      default:        legal_d = 1'b0;
    endcase
    case (ir[14:12])
      3'b000:  take_d = beq;
      3'b001:  take_d = bne;
      3'b100:  take_d = blt;
      3'b101:  take_d = bge;
      3'b110:  take_d = bltu;
      3'b111:  take_d = bgeu;
      default: take_d = 1'b0;
    endcase
  end

  // Each branch of the case sets the outputs that the destination state shows.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      mem_cnt_q   <= '0;
      instret_q   <= '0;
      load_pc_q   <= 1'b0;
      load_ir_q   <= 1'b0;
      we_rf_q     <= 1'b0;
      we_ram_q    <= 1'b0;
      alu_b_imm_q <= 1'b0;
      alu_sub_q   <= 1'b0;
      wb_mem_q    <= 1'b0;
      wb_pc_q     <= 1'b0;
      pc_imm_q    <= 1'b0;
      pc_rs1_q    <= 1'b0;
      busy_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      load_pc_q   <= 1'b0;
      load_ir_q   <= 1'b0;
      we_rf_q     <= 1'b0;
      we_ram_q    <= 1'b0;
      alu_b_imm_q <= 1'b0;
      alu_sub_q   <= 1'b0;
      wb_mem_q    <= 1'b0;
      wb_pc_q     <= 1'b0;
      pc_imm_q    <= 1'b0;
      pc_rs1_q    <= 1'b0;
      busy_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_d) begin
            state_q   <= S_FETCH;
            load_ir_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        S_FETCH: begin
          state_q <= S_DECODE;
          busy_q  <= 1'b1;
        end
        S_DECODE: begin
          op_q <= ir[6:0];
          if (!legal_d) begin
            state_q   <= S_TRAP;
            illegal_q <= 1'b1;
          end else begin
            state_q <= S_EXEC;
            busy_q  <= 1'b1;
            case (ir[6:0])
              OP_ALU: begin
                alu_sub_q <= ir[30];
                we_rf_q   <= 1'b1;
              end
              OP_IMM: begin
                alu_b_imm_q <= 1'b1;
                we_rf_q     <= 1'b1;
              end
              OP_LD, OP_SD: alu_b_imm_q <= 1'b1;
              OP_BR:        pc_imm_q    <= take_d;
              OP_AUIPC: begin
                wb_pc_q  <= 1'b1;
                pc_imm_q <= 1'b1;
                we_rf_q  <= 1'b1;
              end
              OP_JAL, OP_JALR: begin
                wb_pc_q <= 1'b1;
                we_rf_q <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_EXEC: begin
          busy_q <= 1'b1;
          if (is_ld_d || is_sd_d) begin
            state_q     <= S_MEM;
            mem_cnt_q   <= LAT_M1;
            alu_b_imm_q <= 1'b1;
            wb_mem_q    <= is_ld_d;
            we_rf_q     <= is_ld_d && (LAT_M1 == 4'd0);
            we_ram_q    <= is_sd_d && (LAT_M1 == 4'd0);
          end else begin
            state_q   <= S_PCUPD;
            load_pc_q <= 1'b1;
            instret_q <= instret_q + 1'b1;
            case (op_q)
              OP_BR:   pc_imm_q <= pc_imm_q;
              OP_JAL:  pc_imm_q <= 1'b1;
              OP_JALR: begin
                pc_imm_q <= 1'b1;
                pc_rs1_q <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_MEM: begin
          busy_q <= 1'b1;
          if (mem_cnt_q == 4'd0) begin
            state_q   <= S_PCUPD;
            load_pc_q <= 1'b1;
            instret_q <= instret_q + 1'b1;
          end else begin
            // Write enable lands on the final MEM cycle only.
            mem_cnt_q   <= mem_cnt_q - 4'd1;
            alu_b_imm_q <= 1'b1;
            wb_mem_q    <= is_ld_d;
            we_rf_q     <= is_ld_d && (mem_cnt_q == 4'd1);
            we_ram_q    <= is_sd_d && (mem_cnt_q == 4'd1);
          end
        end
        S_PCUPD: begin
`ifdef UC_SINGLE_STEP_EN
          state_q <= S_IDLE;
`else
          if (start_d) begin
            state_q   <= S_FETCH;
            load_ir_q <= 1'b1;
            busy_q    <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
`endif
        end
        S_TRAP:  state_q <= S_TRAP;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign load_pc   = load_pc_q;
  assign load_ir   = load_ir_q;
  assign we_rf     = we_rf_q;
  assign we_ram    = we_ram_q;
  assign alu_b_imm = alu_b_imm_q;
  assign alu_sub   = alu_sub_q;
  assign wb_mem    = wb_mem_q;
  assign wb_pc     = wb_pc_q;
  assign pc_imm    = pc_imm_q;
  assign pc_rs1    = pc_rs1_q;
  assign busy      = busy_q;
  assign illegal   = illegal_q;
  assign instret   = instret_q;

endmodule
